// File: rtl/otter_io_pkg.sv
// Shared register-map constants and types for OTTER IOBUS peripherals.
// Used by the countdown timer (otter_iobus_timer) and its tick generator.
package otter_io_pkg;

    // Byte offsets inside the timer's 32-byte window
    localparam logic [4:0] TMR_CTRL_OFS     = 5'h00;
    localparam logic [4:0] TMR_LOAD_OFS     = 5'h04;
    localparam logic [4:0] TMR_COUNT_OFS    = 5'h08;
    localparam logic [4:0] TMR_STATUS_OFS   = 5'h0C;
    localparam logic [4:0] TMR_PRESCALE_OFS = 5'h10;

    localparam int TMR_CTRL_EN_BIT     = 0;
    localparam int TMR_CTRL_RELOAD_BIT = 1;
    localparam int TMR_CTRL_IE_BIT     = 2;

    localparam int PSC_W = 16;

    typedef struct packed {
        logic ie;
        logic reload;
        logic en;
    } tmr_ctrl_t;

endpackage

// File: rtl/otter_tick_gen.sv
// Tick source for the timer: divides the clock by PRESCALE+1 when
// OTTER_TIMER_PRESCALE_EN is defined, otherwise ticks on every enabled cycle.
module otter_tick_gen
    import otter_io_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic [PSC_W-1:0] prescale,
    input  logic             clear,
    output logic             tick
);

`ifdef OTTER_TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET || clear || !en) begin
            psc <= '0;
        end else if (psc == prescale) begin
            psc <= '0;
        end else begin
            psc <= psc + 1'b1;
        end
    end

    assign tick = en && (psc == prescale);
`else
    logic unusedInputs;
    assign unusedInputs = ^{CLK, RESET, prescale, clear};
    assign tick = en;
`endif

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped countdown timer on the OTTER IOBUS with level interrupt.
// Optional PRESCALE register enabled by defining OTTER_TIMER_PRESCALE_EN.
module otter_iobus_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          CNT_W     = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR,
    output logic        HIT
);

    logic [4:0]       regOfs;
    logic             wrEn, ctrlWr, loadWr, statusWr, pscWr;
    logic             tick, expiry;
    tmr_ctrl_t        ctrl;
    logic [CNT_W-1:0] load, count;
    logic             expired;
    logic [PSC_W-1:0] prescale;
    logic             unusedAddrBits;

    assign unusedAddrBits = ^IOBUS_ADDR[1:0];
    assign regOfs   = {IOBUS_ADDR[4:2], 2'b00};
    assign HIT      = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    assign wrEn     = HIT && IOBUS_WR;
    assign ctrlWr   = wrEn && (regOfs == TMR_CTRL_OFS);
    assign loadWr   = wrEn && (regOfs == TMR_LOAD_OFS);
    assign statusWr = wrEn && (regOfs == TMR_STATUS_OFS);

`ifdef OTTER_TIMER_PRESCALE_EN
    assign pscWr = wrEn && (regOfs == TMR_PRESCALE_OFS);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prescale <= '0;
        end else if (pscWr) begin
            prescale <= IOBUS_OUT[PSC_W-1:0];
        end
    end
`else
    assign pscWr    = 1'b0;
    assign prescale = '0;
`endif

    otter_tick_gen u_tickGen (
        .CLK      (CLK),
        .RESET    (RESET),
        .en       (ctrl.en),
        .prescale (prescale),
        .clear    (pscWr),
        .tick     (tick)
    );

    // A LOAD write replaces the tick outright, so it also suppresses expiry.
    assign expiry = tick && (count == '0) && !loadWr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            if (ctrlWr) begin
                ctrl <= '{ie:     IOBUS_OUT[TMR_CTRL_IE_BIT],
                          reload: IOBUS_OUT[TMR_CTRL_RELOAD_BIT],
                          en:     IOBUS_OUT[TMR_CTRL_EN_BIT]};
            end else if (expiry && !ctrl.reload) begin
                ctrl.en <= 1'b0;
            end

            if (loadWr) begin
                load  <= IOBUS_OUT[CNT_W-1:0];
                count <= IOBUS_OUT[CNT_W-1:0];
            end else if (tick) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else if (ctrl.reload) begin
                    count <= load;
                end
            end

            // A fresh expiry beats a simultaneous write-1-to-clear.
            if (expiry) begin
                expired <= 1'b1;
            end else if (statusWr && IOBUS_OUT[0]) begin
                expired <= 1'b0;
            end
        end
    end

    assign INTR = expired & ctrl.ie;

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        IOBUS_IN = '0;
        if (HIT) begin
            case (regOfs)
                TMR_CTRL_OFS:     IOBUS_IN = 32'(ctrl);
                TMR_LOAD_OFS:     IOBUS_IN[CNT_W-1:0] = load;
                TMR_COUNT_OFS:    IOBUS_IN[CNT_W-1:0] = count;
                TMR_STATUS_OFS:   IOBUS_IN[0] = expired;
`ifdef OTTER_TIMER_PRESCALE_EN
                TMR_PRESCALE_OFS: IOBUS_IN[PSC_W-1:0] = prescale;
`endif
                default:          IOBUS_IN = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Scoreboard bench for otter_iobus_timer: stimulus pushes expected read
// results, a negedge monitor pops and compares them against the bus.
module tb_otter_iobus_timer;

    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        CLK, RESET, IOBUS_WR, INTR, HIT;
    logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        hit;
        logic        intr;
    } exp_t;

    exp_t sb[$];
    exp_t monE;
    logic sampleReq;
    int   checks = 0;
    int   errors = 0;

    otter_iobus_timer #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR),
        .HIT        (HIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, optionally queue an expected read, commit at the edge.
    task automatic busOp(input logic [7:0] ofs, input logic wr, input logic [31:0] wdata,
                         input logic doRd, input logic [31:0] expData, input logic expIntr,
                         input string name);
        exp_t e;
        IOBUS_ADDR = BASE + 32'(ofs);
        IOBUS_WR   = wr;
        IOBUS_OUT  = wdata;
        sampleReq  = doRd;
        if (doRd) begin
            e.name = name;
            e.data = expData;
            e.hit  = (ofs < 8'h20);
            e.intr = expIntr;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        IOBUS_WR  = 1'b0;
        sampleReq = 1'b0;
    endtask

    task automatic rd(input logic [7:0] ofs, input logic [31:0] expData, input logic expIntr,
                      input string name);
        busOp(ofs, 1'b0, 32'h0, 1'b1, expData, expIntr, name);
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [31:0] data);
        busOp(ofs, 1'b1, data, 1'b0, 32'h0, 1'b0, "");
    endtask

    always @(negedge CLK) begin
        if (sampleReq) begin
            if (sb.size() == 0) begin
                check("scoreboard underflow", 32'(sb.size()), 32'd1);
            end else begin
                monE = sb.pop_front();
                check({monE.name, " data"}, IOBUS_IN, monE.data);
                check({monE.name, " hit"}, 32'(HIT), 32'(monE.hit));
                check({monE.name, " intr"}, 32'(INTR), 32'(monE.intr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET      = 1'b1;
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        sampleReq  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Reset state and decode
        rd(8'h00, 0, 0, "rst ctrl");
        rd(8'h04, 0, 0, "rst load");
        rd(8'h08, 0, 0, "rst count");
        rd(8'h0C, 0, 0, "rst status");
        rd(8'h20, 0, 0, "outside window");

        // Periodic: LOAD=3, EN|RELOAD|IE
        wr(8'h04, 3);
        wr(8'h00, 32'h7);
        rd(8'h08, 3, 0, "per c3");
        rd(8'h08, 2, 0, "per c2");
        rd(8'h08, 1, 0, "per c1");
        rd(8'h08, 0, 0, "per c0");
        rd(8'h08, 3, 1, "per reload");
        rd(8'h08, 2, 1, "per 2nd c2");
        rd(8'h08, 1, 1, "per 2nd c1");
        rd(8'h08, 0, 1, "per 2nd c0");
        rd(8'h08, 3, 1, "per 2nd reload");
        rd(8'h0C, 1, 1, "per status");
        rd(8'h08, 1, 1, "per 3rd c1");
        wr(8'h0C, 1);                       // W1C on the expiry cycle
        rd(8'h0C, 1, 1, "w1c vs expiry");
        wr(8'h0C, 1);
        rd(8'h0C, 0, 0, "w1c clears");
        wr(8'h04, 9);                       // LOAD on a tick with COUNT=0
        rd(8'h08, 9, 0, "load over tick");
        rd(8'h0C, 0, 0, "load suppresses expiry");
        rd(8'h08, 7, 0, "count after load");
        wr(8'h00, 0);                       // tick uses pre-write EN
        rd(8'h08, 5, 0, "disable edge tick");
        rd(8'h08, 5, 0, "disabled hold");
        rd(8'h00, 0, 0, "ctrl cleared");

        // One-shot: LOAD=2, EN|IE
        wr(8'h04, 2);
        wr(8'h00, 32'h5);
        rd(8'h08, 2, 0, "os c2");
        rd(8'h08, 1, 0, "os c1");
        rd(8'h08, 0, 0, "os c0");
        rd(8'h00, 4, 1, "os auto disable");
        rd(8'h08, 0, 1, "os count holds");
        rd(8'h0C, 1, 1, "os expired");
        wr(8'h0C, 1);
        rd(8'h0C, 0, 0, "os intr drops");

        // Expiry coinciding with an EN=0 write
        wr(8'h04, 1);
        wr(8'h00, 32'h1);
        rd(8'h08, 1, 0, "en0 c1");
        wr(8'h00, 0);
        rd(8'h0C, 1, 0, "en0 write keeps expiry");
        rd(8'h00, 0, 0, "en0 ctrl");
        rd(8'h08, 0, 0, "en0 count");

        // Written EN wins over auto-disable
        wr(8'h0C, 1);
        wr(8'h00, 32'h1);
        wr(8'h00, 32'h5);
        rd(8'h00, 5, 1, "written en wins");
        wr(8'h00, 0);
        wr(8'h0C, 1);
        rd(8'h0C, 0, 0, "cleanup status");

        // Ignored writes and address decode details
        wr(8'h08, 32'h55);
        rd(8'h08, 0, 0, "count read-only");
        wr(8'h14, 32'hAB);
        rd(8'h14, 0, 0, "unused ofs");
        rd(8'h1C, 0, 0, "unused ofs 1c");
        wr(8'h06, 32'h12);                  // low address bits ignored
        rd(8'h04, 32'h12, 0, "low addr bits");
        rd(8'h08, 32'h12, 0, "load sets count");
        wr(8'h24, 32'hFF);                  // outside the window
        rd(8'h04, 32'h12, 0, "outside write ignored");
        rd(8'h24, 0, 0, "outside read");

`ifdef OTTER_TIMER_PRESCALE_EN
        wr(8'h10, 4);
        rd(8'h10, 4, 0, "prescale reg");
        wr(8'h04, 1);
        wr(8'h00, 32'h3);
        for (int i = 0; i < 5; i++) rd(8'h08, 1, 0, "psc hold 1");
        for (int i = 0; i < 5; i++) rd(8'h08, 0, 0, "psc hold 0");
        rd(8'h08, 1, 0, "psc reload");
        rd(8'h0C, 1, 0, "psc expired");
        wr(8'h00, 0);
        wr(8'h0C, 1);
        wr(8'h10, 0);
`else
        wr(8'h10, 4);
        rd(8'h10, 0, 0, "no prescale reg");
`endif

        // Reset mid-count with INTR asserted
        wr(8'h04, 5);
        wr(8'h00, 32'h7);
        rd(8'h08, 5, 0, "pre-rst c5");
        rd(8'h08, 4, 0, "pre-rst c4");
        rd(8'h08, 3, 0, "pre-rst c3");
        rd(8'h08, 2, 0, "pre-rst c2");
        rd(8'h08, 1, 0, "pre-rst c1");
        rd(8'h08, 0, 0, "pre-rst c0");
        RESET = 1'b1;
        rd(8'h08, 5, 1, "rst cycle count");
        busOp(8'h04, 1'b1, 32'h33, 1'b1, 0, 0, "rst cycle write");
        RESET = 1'b0;
        rd(8'h04, 0, 0, "post-rst load");
        rd(8'h00, 0, 0, "post-rst ctrl");
        rd(8'h08, 0, 0, "post-rst count");
        rd(8'h0C, 0, 0, "post-rst status");
        rd(8'h08, 0, 0, "post-rst idle");

        @(negedge CLK);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
